// File: rtl/seq_sdivmod.sv
// Iterative signed divider: one restoring step per cycle, quotient and remainder together.
// Optional SDIVMOD_FAST_DBZ_EN: a zero divisor skips the iteration and finishes on the next edge.
module seq_sdivmod #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 dbz,
    output logic [1:0]           dbg_state
);

    localparam int W  = DATAWIDTH;
    localparam int W1 = DATAWIDTH + 1;
    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_q;       // dividend magnitude, shifted out as quotient bits shift in
    logic [W:0]      r_rem;
    logic [W:0]      r_b_mag;
    logic [W-1:0]    r_a;
    logic            r_neg_q;
    logic            r_bz;

    logic [W-1:0]    w_a_mag;
    logic [W:0]      w_b_ext;
    logic [W:0]      w_b_mag;
    logic            w_b_zero;
    logic [W+1:0]    w_shift;
    logic [W+1:0]    w_diff;
    logic            w_sub_ok;
    logic [W-1:0]    w_q_fix;
    logic [W-1:0]    w_r_fix;

    // |a| as an unsigned W-bit value already covers |MIN| = 2^(W-1).
    assign w_a_mag  = a[W-1] ? (~a + W'(1)) : a;
    assign w_b_ext  = {b[W-1], b};
    assign w_b_mag  = b[W-1] ? (~w_b_ext + W1'(1)) : w_b_ext;
    assign w_b_zero = (b == '0);

    assign w_shift  = {r_rem, r_q[W-1]};
    assign w_diff   = w_shift - {1'b0, r_b_mag};
    assign w_sub_ok = ~w_diff[W+1];

    assign w_q_fix  = r_neg_q ? -r_q : r_q;
    assign w_r_fix  = r_a[W-1] ? -r_rem[W-1:0] : r_rem[W-1:0];

    assign dbg_state = r_state;

    // Handshake: start is taken on any edge where busy is low (including the done
    // cycle); a request seen while busy is dropped, never queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_b_mag <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_bz    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            dbz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q     <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_rem   <= '0;
                        r_a     <= a;
                        r_neg_q <= a[W-1] ^ b[W-1];
                        r_bz    <= w_b_zero;
                        r_cnt   <= CW'(W);
                        busy    <= 1'b1;
`ifdef SDIVMOD_FAST_DBZ_EN
                        r_state <= w_b_zero ? S_FIX : S_CALC;
`else
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_rem <= w_sub_ok ? w_diff[W:0] : w_shift[W:0];
                    r_q   <= {r_q[W-2:0], w_sub_ok};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor overrides whatever the iteration produced.
                    quot    <= r_bz ? '1  : w_q_fix;
                    rem     <= r_bz ? r_a : w_r_fix;
                    dbz     <= r_bz;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sdivmod.sv
// Bench for seq_sdivmod: an 8-bit instance for directed/protocol/reset cases and a
// 64-bit instance for random operands, both against an arithmetic reference model.
module tb_seq_sdivmod;

    localparam int W8  = 8;
    localparam int W64 = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic           s8, busy8, done8, z8;
    logic [W8-1:0]  a8, b8, q8, r8;
    logic [1:0]     st8;

    logic           s64, busy64, done64, z64;
    logic [W64-1:0] a64, b64, q64, r64;
    logic [1:0]     st64;

    seq_sdivmod #(.DATAWIDTH(W8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .quot(q8), .rem(r8), .dbz(z8),
        .dbg_state(st8)
    );

    seq_sdivmod #(.DATAWIDTH(W64)) u_dut64 (
        .clk(clk), .rst(rst), .start(s64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .quot(q64), .rem(r64), .dbz(z64),
        .dbg_state(st64)
    );

    // ---------------- scoreboard ----------------
    logic [2*W8:0]  exp8_q[$];     // {dbz, quot, rem}
    int             due8_q[$];     // cycle in which done is expected
    logic [2*W64:0] exp64_q[$];
    int             due64_q[$];
    logic [W8-1:0]  last_q8;
    int             n_checks = 0;
    int             n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lat_for(input bit z, input int w);
`ifdef SDIVMOD_FAST_DBZ_EN
        return z ? 1 : w + 1;
`else
        return (z) ? w + 1 : w + 1;
`endif
    endfunction

    // Reference: Verilog signed / and %, with b=0 giving quot=-1, rem=a.
    task automatic push8(input logic [W8-1:0] ia, input logic [W8-1:0] ib, input int acc);
        int sa, sb, q, r;
        bit z;
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        if (sb == 0) begin
            q = -1; r = sa; z = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb; z = 1'b0;
        end
        exp8_q.push_back({z, q[W8-1:0], r[W8-1:0]});
        due8_q.push_back(acc + lat_for(z, W8));
    endtask

    task automatic push64(input logic [W64-1:0] ia, input logic [W64-1:0] ib, input int acc);
        longint sa, sb, q, r;
        bit z;
        sa = $signed(ia);
        sb = $signed(ib);
        if (sb == 0) begin
            q = -1; r = sa; z = 1'b1;
        end else if (sb == -1) begin
            q = -sa; r = 0; z = 1'b0;   // MIN / -1 wraps back to MIN
        end else begin
            q = sa / sb; r = sa % sb; z = 1'b0;
        end
        exp64_q.push_back({z, q, r});
        due64_q.push_back(acc + lat_for(z, W64));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step8(input bit st, input logic [W8-1:0] ia, input logic [W8-1:0] ib);
        @(negedge clk);
        a8 = ia; b8 = ib; s8 = st;
        if (st && !busy8) push8(ia, ib, cyc + 1);
        @(posedge clk);
        #1 s8 = 1'b0;
    endtask

    task automatic step64(input bit st, input logic [W64-1:0] ia, input logic [W64-1:0] ib,
                          output bit acc);
        @(negedge clk);
        a64 = ia; b64 = ib; s64 = st;
        acc = st && !busy64;
        if (acc) push64(ia, ib, cyc + 1);
        @(posedge clk);
        #1 s64 = 1'b0;
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 300 && exp8_q.size() != 0; i++) @(negedge clk);
        check("idle8_outstanding", 64'(exp8_q.size()), 64'd0);
        exp8_q.delete();
        due8_q.delete();
    endtask

    task automatic wait_idle64();
        for (int i = 0; i < 300 && exp64_q.size() != 0; i++) @(negedge clk);
        check("idle64_outstanding", 64'(exp64_q.size()), 64'd0);
        exp64_q.delete();
        due64_q.delete();
    endtask

    function automatic logic [W8-1:0] pick8();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h7f;
            3: return 8'hff;
            4: return 8'h01;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [W64-1:0] pick64();
        case ($urandom_range(0, 9))
            0: return 64'h0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h7fff_ffff_ffff_ffff;
            3: return '1;
            4: return 64'h1;
            5: return 64'($urandom_range(0, 100));
            6: return -64'($urandom_range(1, 100));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- monitors ----------------
    task automatic mon8();
        logic [2*W8:0] e;
        int t;
        forever begin
            @(negedge clk);
            if (!rst && done8) begin
                if (exp8_q.size() == 0) begin
                    check("done8_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp8_q.pop_front();
                    t = due8_q.pop_front();
                    check("quot8", 64'(q8), 64'(e[2*W8-1:W8]));
                    check("rem8",  64'(r8), 64'(e[W8-1:0]));
                    check("dbz8",  64'(z8), 64'(e[2*W8]));
                    check("done8_cycle", 64'(cyc), 64'(t));
                    check("busy8_at_done", 64'(busy8), 64'd0);
                    last_q8 = e[2*W8-1:W8];
                end
            end
        end
    endtask

    task automatic mon64();
        logic [2*W64:0] e;
        int t;
        forever begin
            @(negedge clk);
            if (!rst && done64) begin
                if (exp64_q.size() == 0) begin
                    check("done64_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp64_q.pop_front();
                    t = due64_q.pop_front();
                    check("quot64", q64, e[2*W64-1:W64]);
                    check("rem64",  r64, e[W64-1:0]);
                    check("dbz64",  64'(z64), 64'(e[2*W64]));
                    check("done64_cycle", 64'(cyc), 64'(t));
                end
            end
        end
    endtask

    // ---------------- directed operand table ----------------
    logic [W8-1:0] dir_a [13] = '{8'd100, -8'sd100, 8'd100, -8'sd100, 8'h80, 8'h80, 8'd5,
                                  -8'sd5, 8'h80, 8'd127, 8'd0, 8'h80, 8'hff};
    logic [W8-1:0] dir_b [13] = '{8'd7, 8'd7, -8'sd7, -8'sd7, 8'hff, 8'd1, 8'd0,
                                  8'd0, 8'd0, 8'h80, 8'd5, 8'h80, 8'h7f};

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        int n64;

        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s64 = 1'b0; a64 = '0; b64 = '0;
        last_q8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_quot8", 64'(q8), 64'd0);
        check("rst_rem8",  64'(r8), 64'd0);
        check("rst_dbz8",  64'(z8), 64'd0);
        check("rst_quot64", q64, 64'd0);
        check("rst_busy64", 64'(busy64), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        fork
            mon8();
            mon64();
        join_none

        // First operation: busy high for exactly DATAWIDTH+1 cycles.
        step8(1'b1, 8'd100, 8'd7);
        for (int i = 0; i <= W8; i++) begin
            @(negedge clk);
            check("busy8_high", 64'(busy8), 64'd1);
        end
        @(negedge clk);
        check("busy8_low", 64'(busy8), 64'd0);
        wait_idle8();

        // Sign and boundary cases; results must hold while idle.
        for (int i = 0; i < 13; i++) begin
            step8(1'b1, dir_a[i], dir_b[i]);
            wait_idle8();
            repeat (2) @(negedge clk);
            check("hold_quot8", 64'(q8), 64'(last_q8));
        end

        // Requests while busy are dropped.
        step8(1'b1, 8'd100, 8'd7);
        for (int i = 0; i < 4; i++) step8(1'b1, 8'($urandom), 8'($urandom));
        wait_idle8();

        // Start held high with operands changing every cycle: back-to-back ops.
        for (int i = 0; i < 400; i++) step8(1'b1, pick8(), pick8());
        wait_idle8();

        // Asynchronous reset in the middle of an operation.
        step8(1'b1, 8'd50, 8'd3);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy8", 64'(busy8), 64'd0);
        check("midrst_done8", 64'(done8), 64'd0);
        check("midrst_quot8", 64'(q8), 64'd0);
        check("midrst_rem8",  64'(r8), 64'd0);
        check("midrst_dbz8",  64'(z8), 64'd0);
        exp8_q.delete();
        due8_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        step8(1'b1, 8'd77, -8'sd9);
        wait_idle8();

        // Random start/idle mix on the narrow instance.
        for (int i = 0; i < 600; i++) step8(1'($urandom_range(0, 1)), pick8(), pick8());
        wait_idle8();

        // Random operands on the 64-bit instance, start held high.
        n64 = 0;
        for (int c = 0; c < 120 * 80 && n64 < 120; c++) begin
            step64(1'b1, pick64(), pick64(), acc);
            if (acc) n64++;
        end
        check("ops64_accepted", 64'(n64), 64'd120);
        wait_idle64();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
